// File: rtl/btc_nonce_scheduler.sv
// btc_nonce_scheduler: sweeps a nonce range round-robin across SHA-256d cores and latches the golden nonce
// Ports:
//   wb_clk_i, wb_rst_i       clock and synchronous active-high reset
//   start, stop              one-cycle run control pulses
//   nonce_start, nonce_end   inclusive sweep range, sampled on start
//   core_ready/done/hit      per-core accept, completion pulse and target-met qualifier
//   core_start, core_nonce   one-hot dispatch strobe and the nonce handed over with it
//   busy                     run in progress (DISPATCH or DRAIN)
//   found, found_nonce       first winning nonce of the run
//   exhausted                range swept to the end with no hit and no abort
//   hashes_done              saturating count of accepted core results this run
//   irq                      one-cycle pulse on entry to DONE
module btc_nonce_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = 32
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 start,
   input  logic                 stop,
   input  logic [NONCE_W-1:0]   nonce_start,
   input  logic [NONCE_W-1:0]   nonce_end,
   input  logic [NUM_CORES-1:0] core_ready,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_hit,
   output logic [NUM_CORES-1:0] core_start,
   output logic [NONCE_W-1:0]   core_nonce,
   output logic                 busy,
   output logic                 found,
   output logic [NONCE_W-1:0]   found_nonce,
   output logic                 exhausted,
   output logic [31:0]          hashes_done,
   output logic                 irq
);
   localparam int IW = $clog2(NUM_CORES);
   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
   state_t               state_q;
   logic [NONCE_W-1:0]   end_q, next_q, found_nonce_q;
   logic [NONCE_W-1:0]   nonce_q [NUM_CORES];
   logic [NUM_CORES-1:0] inflight_q, elig, acc, hits, disp;
   logic [IW-1:0]        rr_q, sel, hit_idx;
   logic [IW:0]          wrap;
   logic                 found_q, exhausted_q, irq_q, aborted_q;
   logic                 sel_v, new_hit, go, last, drained;
   logic [31:0]          hashes_q, hashes_d;
   logic [32:0]          sum;
   always_comb begin
      elig    = core_ready & ~inflight_q;
      acc     = core_done & inflight_q;
      hits    = acc & core_hit;
      new_hit = |hits & ~found_q;
      sel     = '0;
      sel_v   = 1'b0;
      wrap    = '0;
      // scan starts at the round-robin pointer and wraps past the top core
      for (int k = 0; k < NUM_CORES; k++) begin
         wrap = {1'b0, rr_q} + (IW+1)'(k);
         wrap = (wrap >= (IW+1)'(NUM_CORES)) ? wrap - (IW+1)'(NUM_CORES) : wrap;
         if (!sel_v && elig[wrap[IW-1:0]]) begin
            sel   = wrap[IW-1:0];
            sel_v = 1'b1;
         end
      end
      // descending scan so the lowest-index simultaneous hit wins
      hit_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (hits[i]) hit_idx = IW'(i);
      // a stop or a fresh hit suppresses dispatch in the same cycle
      go       = (state_q == DISPATCH) && !wb_rst_i && !stop && !new_hit && sel_v;
      disp     = go ? (NUM_CORES'(1) << sel) : '0;
      last     = go && (next_q == end_q);
      drained  = (inflight_q & ~acc) == '0;
      sum      = {1'b0, hashes_q} + 33'($countones(acc));
      hashes_d = sum[32] ? '1 : sum[31:0];
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q       <= IDLE;
         end_q         <= '0;
         next_q        <= '0;
         inflight_q    <= '0;
         rr_q          <= '0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         exhausted_q   <= 1'b0;
         hashes_q      <= '0;
         irq_q         <= 1'b0;
         aborted_q     <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
      end else begin
         irq_q      <= 1'b0;
         inflight_q <= (inflight_q & ~acc) | disp;
         hashes_q   <= hashes_d;
         if (go) begin
            nonce_q[sel] <= next_q;
            next_q       <= next_q + 1'b1;
            rr_q         <= (sel == IW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
         end
         if (new_hit) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce_q[hit_idx];
         end
         case (state_q)
            IDLE, DONE: if (start) begin
               end_q         <= nonce_end;
               next_q        <= nonce_start;
               found_q       <= 1'b0;
               found_nonce_q <= '0;
               exhausted_q   <= 1'b0;
               hashes_q      <= '0;
               aborted_q     <= 1'b0;
               state_q       <= DISPATCH;
            end
            DISPATCH: if (stop || new_hit || last) begin
               aborted_q <= stop;
               state_q   <= DRAIN;
            end
            DRAIN: if (drained) begin
               // a hit on the final drained result still counts as found
               exhausted_q <= ~(found_q | new_hit) & ~aborted_q;
               irq_q       <= 1'b1;
               state_q     <= DONE;
            end
            default: ;
         endcase
      end
   end
   assign core_start  = disp;
   assign core_nonce  = go ? next_q : '0;
   assign busy        = (state_q == DISPATCH) || (state_q == DRAIN);
   assign found       = found_q;
   assign found_nonce = found_nonce_q;
   assign exhausted   = exhausted_q;
   assign hashes_done = hashes_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_btc_nonce_scheduler.sv
// tb_btc_nonce_scheduler: scoreboard bench with behavioural hash cores for the nonce scheduler
module tb_btc_nonce_scheduler;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [31:0] nonce_start = '0, nonce_end = '0;
   logic [3:0]  core_ready = '0, core_done = '0, core_hit = '0;
   logic [3:0]  core_start;
   logic [31:0] core_nonce, found_nonce, hashes_done;
   logic        busy, found, exhausted, irq;
   int          errors = 0, checks = 0;
   logic [35:0] sb [$];
   int          disp_cyc [$];
   int          cyc = 0, disp_cnt = 0, irq_cnt = 0, lat = 0;
   logic [3:0]  act = '0, hold = '0, stray = '0, done_nx = '0, hit_nx = '0;
   logic [31:0] held [4];
   int          cnt [4];
   logic        gen = 1'b0;
   logic [31:0] g0 = '0, g1 = '0;
   logic [35:0] e;
   always #5 clk = ~clk;
   btc_nonce_scheduler #(.NUM_CORES(4), .NONCE_W(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .stop(stop),
      .nonce_start(nonce_start), .nonce_end(nonce_end),
      .core_ready(core_ready), .core_done(core_done), .core_hit(core_hit),
      .core_start(core_start), .core_nonce(core_nonce), .busy(busy),
      .found(found), .found_nonce(found_nonce), .exhausted(exhausted),
      .hashes_done(hashes_done), .irq(irq)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(input int c, input logic [31:0] n);
      sb.push_back({4'(1 << c), n});
   endtask
   // core outputs change after the edge, and after stimulus written at #1
   always @(posedge clk) begin
      #2;
      core_done = done_nx | stray;
      core_hit  = hit_nx;
   end
   // monitor: scoreboard pops on dispatch, cores finish lat cycles later unless held
   always @(negedge clk) begin
      cyc++;
      if (irq) irq_cnt++;
      if (rst) begin
         act = '0; done_nx = '0; hit_nx = '0;
         sb.delete(); disp_cyc.delete();
      end else begin
         act = act & ~core_done;
         done_nx = '0; hit_nx = '0;
         for (int i = 0; i < 4; i++)
            if (act[i]) begin
               if (cnt[i] > 0) cnt[i]--;
               else if (!hold[i]) begin
                  done_nx[i] = 1'b1;
                  hit_nx[i]  = gen && (held[i] == g0 || held[i] == g1);
               end
            end
         if (core_start == '0) check("idle_nonce", core_nonce, 0);
         else if (sb.size() == 0) check("extra_disp", {core_start, core_nonce}, 0);
         else begin
            e = sb.pop_front();
            check("disp", {core_start, core_nonce}, e);
            for (int i = 0; i < 4; i++)
               if (core_start[i]) begin act[i] = 1'b1; held[i] = core_nonce; cnt[i] = lat; end
            disp_cnt++;
            disp_cyc.push_back(cyc);
         end
      end
   end
   task automatic reset_dut();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; stop = 1'b0; core_ready = '0;
      hold = '0; stray = '0; gen = 1'b0; lat = 0;
      @(negedge clk); @(negedge clk);
      check("rst_core_start", core_start, 0);
      check("rst_busy", busy, 0);
      check("rst_found", found, 0);
      check("rst_found_nonce", found_nonce, 0);
      check("rst_exhausted", exhausted, 0);
      check("rst_hashes", hashes_done, 0);
      check("rst_irq", irq, 0);
      @(posedge clk); #1 rst = 1'b0;
   endtask
   task automatic run(input logic [31:0] s, input logic [31:0] n);
      @(posedge clk); #1;
      nonce_start = s; nonce_end = n; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask
   task automatic wait_done(input int base);
      int n = 0;
      while (irq_cnt == base && n < 1000) begin @(negedge clk); n++; end
      check("done_seen", irq_cnt != base, 1);
      repeat (3) @(negedge clk);
   endtask
   task automatic wait_disp(input int target);
      int n = 0;
      while (disp_cnt < target && n < 1000) begin @(negedge clk); n++; end
      check("disp_seen", disp_cnt >= target, 1);
   endtask
   initial begin
      int bi, bd, n;
      reset_dut();
      // eight nonces over four always-ready cores, no hits
      core_ready = 4'hF;
      for (int k = 0; k < 8; k++) push(k % 4, 32'h10 + k);
      bi = irq_cnt;
      run(32'h10, 32'h17);
      wait_done(bi);
      check("t1_exhausted", exhausted, 1);
      check("t1_found", found, 0);
      check("t1_hashes", hashes_done, 8);
      check("t1_irq_pulses", irq_cnt - bi, 1);
      check("t1_sb_left", sb.size(), 0);
      check("t1_ndisp", disp_cyc.size(), 8);
      check("t1_span", disp_cyc[7] - disp_cyc[0], 7);
      check("t1_busy", busy, 0);
      // range that wraps through all-ones, then a single-nonce range from DONE
      reset_dut();
      core_ready = 4'hF;
      push(0, 32'hFFFF_FFFE); push(1, 32'hFFFF_FFFF); push(2, 32'h0); push(3, 32'h1);
      bi = irq_cnt;
      run(32'hFFFF_FFFE, 32'h1);
      wait_done(bi);
      check("t2_exhausted", exhausted, 1);
      check("t2_hashes", hashes_done, 4);
      check("t2_sb_left", sb.size(), 0);
      push(0, 32'h5);
      bi = irq_cnt; bd = disp_cnt;
      run(32'h5, 32'h5);
      wait_done(bi);
      check("t2b_ndisp", disp_cnt - bd, 1);
      check("t2b_hashes", hashes_done, 1);
      check("t2b_exhausted", exhausted, 1);
      check("t2b_found", found, 0);
      // core 2 hits while the other three are held in flight
      reset_dut();
      core_ready = 4'hF; hold = 4'b1011; gen = 1'b1; g0 = 32'h1234; g1 = 32'h1235;
      push(0, 32'h1232); push(1, 32'h1233); push(2, 32'h1234); push(3, 32'h1235);
      bi = irq_cnt;
      run(32'h1232, 32'h12FF);
      n = 0;
      while (!found && n < 200) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      check("t3_found", found, 1);
      check("t3_found_nonce", found_nonce, 32'h1234);
      check("t3_draining", busy, 1);
      check("t3_no_irq_yet", irq_cnt - bi, 0);
      @(posedge clk); #1 hold = '0;
      wait_done(bi);
      check("t3_keep_nonce", found_nonce, 32'h1234);
      check("t3_exhausted", exhausted, 0);
      check("t3_hashes", hashes_done, 4);
      check("t3_sb_left", sb.size(), 0);
      // cores 1 and 3 hit in the same cycle
      reset_dut();
      core_ready = 4'b1010; hold = 4'b1010; gen = 1'b1; g0 = 32'h100; g1 = 32'h101;
      push(1, 32'h100); push(3, 32'h101);
      bi = irq_cnt; bd = disp_cnt;
      run(32'h100, 32'h1FF);
      wait_disp(bd + 2);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 hold = '0;
      wait_done(bi);
      check("t4_found", found, 1);
      check("t4_found_nonce", found_nonce, 32'h100);
      check("t4_hashes", hashes_done, 2);
      check("t4_exhausted", exhausted, 0);
      // only core 2 ready; start while busy ignored; stop aborts
      reset_dut();
      core_ready = 4'b0100; lat = 2;
      for (int k = 0; k < 16; k++) push(2, 32'h40 + k);
      bi = irq_cnt; bd = disp_cnt;
      run(32'h40, 32'h4F);
      wait_disp(bd + 1);
      run(32'h999, 32'h999);
      wait_disp(bd + 3);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_done(bi);
      check("t5_ndisp", disp_cnt - bd, 3);
      check("t5_sb_left", sb.size(), 13);
      check("t5_exhausted", exhausted, 0);
      check("t5_found", found, 0);
      check("t5_hashes", hashes_done, 3);
      check("t5_irq_pulses", irq_cnt - bi, 1);
      // reset mid-run with cores in flight
      reset_dut();
      core_ready = 4'hF; hold = 4'b1110;
      for (int k = 0; k < 16; k++) push(k < 4 ? k : 0, 32'h200 + k);
      bi = irq_cnt; bd = disp_cnt;
      run(32'h200, 32'h2FF);
      wait_disp(bd + 6);
      check("t6_pre_busy", busy, 1);
      check("t6_pre_hashes", hashes_done != 0, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_busy", busy, 0);
      check("t6_core_start", core_start, 0);
      check("t6_found", found, 0);
      check("t6_exhausted", exhausted, 0);
      check("t6_hashes", hashes_done, 0);
      check("t6_irq", irq, 0);
      @(posedge clk); #1 stray = 4'hF;
      @(posedge clk); #1 stray = '0;
      repeat (3) @(negedge clk);
      check("t6_stray_hashes", hashes_done, 0);
      check("t6_no_irq", irq_cnt - bi, 0);
      check("t6_idle", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/btc_nonce_scheduler.md
Name: btc_nonce_scheduler

Overview:
Sequences the SHA-256d hash cores of the user-project miner. Sweeps a programmed nonce range, dispatching one nonce per cycle round-robin to idle cores, and tracks which nonce each core holds. Collects core results, latches the first winning (golden) nonce, and reports completion status and an interrupt to the Wishbone register block.

Parameters:
NUM_CORES, 4, number of hash cores served (2..16)
NONCE_W, 32, nonce width in bits

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
stop  input  1  one-cycle pulse; aborts dispatch
nonce_start  input  NONCE_W  first nonce of range, sampled on start
nonce_end  input  NONCE_W  last nonce of range, inclusive, sampled on start
core_ready  input  NUM_CORES  core i can accept a nonce
core_done  input  NUM_CORES  one-cycle pulse; core i finished its nonce
core_hit  input  NUM_CORES  qualifies core_done: hash met target
core_start  output  NUM_CORES  one-hot pulse; dispatch to core i
core_nonce  output  NONCE_W  nonce for the core flagged by core_start
busy  output  1  state is DISPATCH or DRAIN
found  output  1  golden nonce latched this run
found_nonce  output  NONCE_W  golden nonce
exhausted  output  1  range fully swept with no hit
hashes_done  output  32  count of accepted core_done events this run
irq  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset: state IDLE; all outputs 0; inflight, rr pointer, internal nonce cleared. Reset mid-run abandons everything immediately, no irq.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE/DONE + start: latch range, next_nonce <= nonce_start, clear found/found_nonce/exhausted/hashes_done, go DISPATCH. start in DISPATCH/DRAIN ignored.
- Eligible core: core_ready[i] & ~inflight[i]. In DISPATCH, at most one dispatch per cycle: first eligible index at or after rr_ptr (wrapping); core_start[i]=1, core_nonce=next_nonce, inflight[i] set next cycle, rr_ptr <= i+1 mod NUM_CORES. No eligible core: no pulse, no advance.
- core_nonce is registered per core (inflight_nonce[i]) at dispatch; core_nonce output 0 when core_start is 0.
- Range: next_nonce increments mod 2^NONCE_W. nonce_end < nonce_start means wrap through all-ones to 0. nonce_end == nonce_start means exactly one nonce. Full range (end = start-1) dispatches 2^NONCE_W nonces.
- Dispatch of nonce == latched nonce_end -> DRAIN next cycle.
- core_done[i] with inflight[i]=1: clear inflight[i], hashes_done++ (saturate at all-ones). core_done on a non-inflight core is ignored (no count). Done and re-dispatch to the same core in the same cycle are not possible (inflight still set that cycle).
- Hit: core_done[i] & core_hit[i] & inflight[i] & ~found: found <= 1, found_nonce <= inflight_nonce[i]. Multiple simultaneous hits: lowest index wins. Later hits, including in DRAIN, are counted but do not overwrite. A hit in DISPATCH -> DRAIN; no dispatch in that cycle.
- stop in DISPATCH -> DRAIN (no dispatch that cycle). stop in DRAIN/IDLE/DONE ignored.
- DRAIN: no dispatch; on inflight == 0 (including done pulses clearing the last bit that cycle) -> DONE.
- Entering DONE: irq=1 for one cycle; exhausted <= ~found & ~aborted (aborted = run ended by stop). Status held until next start or reset.
- busy is combinational from state.

Test Plan:
- NUM_CORES=4, all ready, range 0x10..0x17, no hits -> core_start 1,2,4,8,1,2,4,8 on consecutive cycles with nonces 0x10..0x17; after all done: exhausted=1, found=0, hashes_done=8, single irq pulse.
- Range 0xFFFFFFFE..0x00000001 -> dispatched nonces FFFFFFFE, FFFFFFFF, 0, 1 then DRAIN; range 5..5 -> exactly one dispatch.
- Core 2 reports hit on nonce 0x1234 while cores 0,1,3 in flight -> dispatch stops next cycle; found_nonce=0x1234; DONE only after the other three core_done; later hit on core 3 does not overwrite.
- Cores 1 and 3 hit same cycle -> found_nonce = core 1's nonce.
- Only core 2 ready, others low -> all dispatches to core 2, one per done; stop mid-run -> DRAIN, DONE with exhausted=0, found=0; start while busy ignored.
- wb_rst_i asserted in DISPATCH with cores in flight -> next cycle IDLE, all outputs 0, no irq; stray core_done afterwards does not increment hashes_done.
